// File: rtl/bit4count_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bit4count_pkg
//  Purpose  : Shared types and constants for the 4-bit counter sequence
//             checker (state encoding, hex 7-segment table).
//  Revision : 1.0  initial release
// ============================================================================
package bit4count_pkg;

  // Checker state: waiting for first sample, tracking, or recovering lock
  typedef enum logic [1:0] {
    ACQ    = 2'd0,
    TRACK  = 2'd1,
    RESYNC = 2'd2
  } chk_state_t;

  // Active-high segments {g,f,e,d,c,b,a} for hex digits 0..F
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage
`default_nettype wire

// File: rtl/bit4count_checker_hex_to_seg7.sv
`default_nettype none
// ============================================================================
//  Module   : hex_to_seg7
//  Purpose  : Combinational hex digit to 7-segment pattern lookup.
//  Revision : 1.0  initial release
// ============================================================================
module hex_to_seg7
  import bit4count_pkg::*;
(
  input  logic [3:0] i_val,
  output logic [6:0] o_seg
);

  // Plain table lookup; the parent registers the result
  assign o_seg = SEG_LUT[i_val];

endmodule
`default_nettype wire

// File: rtl/bit4count_checker.sv
`default_nettype none
// ============================================================================
//  Module   : bit4count_checker
//  Purpose  : Receive-side sequence checker for a 4-bit binary up-counter.
//             Tracks the expected next value, flags skips/repeats, reports
//             F->0 wraps and counts mismatches (saturating).
//             Optional macro BIT4COUNT_CHECKER_SEG_EN adds a registered
//             hex 7-segment view (o_seg) of the last sample.
//  Revision : 1.0  initial release
// ============================================================================
module bit4count_checker
  import bit4count_pkg::*;
#(
  parameter int RELOCK_N = 4,   // good samples needed to regain lock (1..15)
  parameter int ERR_W    = 8    // width of the saturating error counter
) (
  input  logic             clk,
  input  logic             reset,      // synchronous, active-low
  input  logic             i_a,        // counter bit 3 (MSB)
  input  logic             i_b,
  input  logic             i_c,
  input  logic             i_d,        // counter bit 0 (LSB)
  output logic             o_locked,
  output logic             o_err,
  output logic             o_wrap,
  output logic [ERR_W-1:0] o_err_cnt,
  output logic [3:0]       o_expect
`ifdef BIT4COUNT_CHECKER_SEG_EN
  ,
  output logic [6:0]       o_seg
`endif
);

  localparam logic [3:0] c_relock_n = 4'(RELOCK_N);

  chk_state_t       r_state, w_state;
  logic [3:0]       r_expect, w_expect;
  logic [3:0]       r_good, w_good;
  logic             r_locked, w_locked;
  logic             r_err, w_err;
  logic             r_wrap, w_wrap;
  logic [ERR_W-1:0] r_err_cnt, w_err_cnt;

  logic [3:0]       w_s;
  logic             w_match;
  logic [ERR_W-1:0] w_err_cnt_inc;
  logic [3:0]       w_good_inc;

  assign w_s           = {i_a, i_b, i_c, i_d};
  assign w_match       = (w_s == r_expect);
  assign w_err_cnt_inc = (&r_err_cnt) ? r_err_cnt : r_err_cnt + ERR_W'(1);
  assign w_good_inc    = r_good + 4'd1;

  // Next-state and next-output decode; expect is always re-seeded from the sample
  always_comb begin
    w_state   = r_state;
    w_expect  = w_s + 4'd1;
    w_good    = r_good;
    w_locked  = r_locked;
    w_err     = 1'b0;
    w_wrap    = 1'b0;
    w_err_cnt = r_err_cnt;
    case (r_state)
      ACQ: begin
        w_state  = TRACK;
        w_locked = 1'b1;
        w_good   = 4'd0;
      end
      TRACK: begin
        if (w_match) begin
          w_wrap = (w_s == 4'd0);
        end else begin
          w_err     = 1'b1;
          w_err_cnt = w_err_cnt_inc;
          w_good    = 4'd0;
          w_locked  = 1'b0;
          w_state   = RESYNC;
        end
      end
      RESYNC: begin
        if (w_match) begin
          w_wrap = (w_s == 4'd0);
          w_good = w_good_inc;
          if (w_good_inc == c_relock_n) begin
            w_locked = 1'b1;
            w_state  = TRACK;
          end
        end else begin
          w_err     = 1'b1;
          w_err_cnt = w_err_cnt_inc;
          w_good    = 4'd0;
        end
      end
      default: begin
        w_state  = ACQ;
        w_locked = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears everything and re-enters ACQ
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ACQ;
      r_expect  <= 4'd0;
      r_good    <= 4'd0;
      r_locked  <= 1'b0;
      r_err     <= 1'b0;
      r_wrap    <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_state   <= w_state;
      r_expect  <= w_expect;
      r_good    <= w_good;
      r_locked  <= w_locked;
      r_err     <= w_err;
      r_wrap    <= w_wrap;
      r_err_cnt <= w_err_cnt;
    end
  end

  assign o_locked  = r_locked;
  assign o_err     = r_err;
  assign o_wrap    = r_wrap;
  assign o_err_cnt = r_err_cnt;
  assign o_expect  = r_expect;

`ifdef BIT4COUNT_CHECKER_SEG_EN
  logic [6:0] w_seg;
  logic [6:0] r_seg;

  hex_to_seg7 u_hex_to_seg7 (
    .i_val (w_s),
    .o_seg (w_seg)
  );

  // Register the segment pattern of the current sample
  always_ff @(posedge clk) begin
    if (!reset) r_seg <= 7'h00;
    else        r_seg <= w_seg;
  end

  assign o_seg = r_seg;
`endif

endmodule
`default_nettype wire
